qsys_btn_irq_master: RTL and testbench

//  Avalon-MM initiator for the 8-bit edge-capture button PIO slave. It services the
//  PIO interrupt in hardware, without CPU involvement:
//    - read the edge-capture register, clear the captured bits, read the pin levels;
//    - present one event record on a valid/ready stream;
//    - maintain per-bit toggle outputs and an event counter.

---
 rtl/qsys_btn_irq_master.sv | 156 +++++++++++++++
 tb/tb_qsys_btn_irq_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_btn_irq_master.sv
// Avalon-MM initiator that services the 8-bit edge-capture button PIO interrupt in hardware
// and publishes each serviced interrupt as an event record on a valid/ready stream.
module qsys_btn_irq_master #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_MASK   = {DATA_WIDTH{1'b1}},
    parameter logic [DATA_WIDTH-1:0] TOGGLE_INIT = '0,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [1:0]            avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write_n,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata,
    input  logic                  irq,
    input  logic                  mask_wr,
    input  logic [DATA_WIDTH-1:0] mask_value,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [DATA_WIDTH-1:0] evt_edges,
    output logic [DATA_WIDTH-1:0] evt_level,
    output logic [DATA_WIDTH-1:0] toggle_out,
    output logic [CNT_WIDTH-1:0]  evt_count,
    output logic                  busy
);

    typedef enum logic [3:0] {
        S_INIT_WR, S_IDLE, S_MASK_WR, S_EC_ADDR, S_EC_DATA,
        S_EC_CLR, S_LV_ADDR, S_LV_DATA, S_EMIT
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    state_t                  state_reg, state_next;
    logic [1:0]              addr_reg, addr_next;
    logic                    cs_reg, cs_next;
    logic                    wr_n_reg, wr_n_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic                    valid_reg;
    logic [DATA_WIDTH-1:0]   edges_reg, level_reg, toggle_reg;
    logic [CNT_WIDTH-1:0]    count_reg;
    logic                    pend_reg;
    logic [DATA_WIDTH-1:0]   mask_val_reg;
    logic [DATA_WIDTH-1:0]   rd_bits;
    logic                    unused_rd;
    logic                    accept;

    assign rd_bits   = avm_readdata[DATA_WIDTH-1:0];
    assign unused_rd = ^avm_readdata[31:DATA_WIDTH];
    assign accept    = (state_reg == S_EMIT) && evt_ready;

    // Bus outputs are registered from the next state so they are glitch-free and
    // line up exactly with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_INIT_WR;
            addr_reg     <= '0;
            cs_reg       <= 1'b0;
            wr_n_reg     <= 1'b1;
            wdata_reg    <= '0;
            valid_reg    <= 1'b0;
            edges_reg    <= '0;
            level_reg    <= '0;
            toggle_reg   <= TOGGLE_INIT;
            count_reg    <= '0;
            pend_reg     <= 1'b0;
            mask_val_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            cs_reg    <= cs_next;
            wr_n_reg  <= wr_n_next;
            wdata_reg <= wdata_next;
            valid_reg <= (state_next == S_EMIT);
            if (state_reg == S_EC_DATA)
                edges_reg <= rd_bits;
            if (state_reg == S_LV_DATA)
                level_reg <= rd_bits;
            if (accept) begin
                toggle_reg <= toggle_reg ^ edges_reg;
                count_reg  <= count_reg + 1'b1;
            end
            // A new request in the MASK_WR cycle itself re-arms the flag.
            if (mask_wr) begin
                pend_reg     <= 1'b1;
                mask_val_reg <= mask_value;
            end else if (state_reg == S_MASK_WR) begin
                pend_reg <= 1'b0;
            end
        end
    end

    // INIT_WR is held until its write has actually been driven for one cycle after reset.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT_WR: state_next = cs_reg ? S_IDLE : S_INIT_WR;
            S_IDLE: begin
                if (pend_reg)
                    state_next = S_MASK_WR;
                else if (irq)
                    state_next = S_EC_ADDR;
            end
            S_MASK_WR: state_next = S_IDLE;
            S_EC_ADDR: state_next = S_EC_DATA;
            S_EC_DATA: state_next = (rd_bits == '0) ? S_IDLE : S_EC_CLR;
            S_EC_CLR:  state_next = S_LV_ADDR;
            S_LV_ADDR: state_next = S_LV_DATA;
            S_LV_DATA: state_next = S_EMIT;
            S_EMIT:    state_next = evt_ready ? S_IDLE : S_EMIT;
            default:   state_next = S_INIT_WR;
        endcase
    end

    always_comb begin
        addr_next  = '0;
        cs_next    = 1'b0;
        wr_n_next  = 1'b1;
        wdata_next = '0;
        case (state_next)
            S_INIT_WR: begin
                cs_next = 1'b1; wr_n_next = 1'b0; addr_next = ADDR_MASK; wdata_next = INIT_MASK;
            end
            S_MASK_WR: begin
                cs_next = 1'b1; wr_n_next = 1'b0; addr_next = ADDR_MASK; wdata_next = mask_val_reg;
            end
            S_EC_ADDR: begin
                cs_next = 1'b1; addr_next = ADDR_EDGE;
            end
            S_EC_DATA: addr_next = ADDR_EDGE;
            // Only reachable from EC_DATA, where readdata holds the captured edges.
            S_EC_CLR: begin
                cs_next = 1'b1; wr_n_next = 1'b0; addr_next = ADDR_EDGE; wdata_next = rd_bits;
            end
            S_LV_ADDR: begin
                cs_next = 1'b1; addr_next = ADDR_DATA;
            end
            default: ;
        endcase
    end

    assign avm_address    = addr_reg;
    assign avm_chipselect = cs_reg;
    assign avm_write_n    = wr_n_reg;
    assign avm_writedata  = 32'(wdata_reg);
    assign evt_valid      = valid_reg;
    assign evt_edges      = edges_reg;
    assign evt_level      = level_reg;
    assign toggle_out     = toggle_reg;
    assign evt_count      = count_reg;
    assign busy           = (state_reg != S_IDLE);

endmodule

// File: tb/tb_qsys_btn_irq_master.sv
// Directed bench for qsys_btn_irq_master against a small cycle model of the edge-capture PIO.
module tb_qsys_btn_irq_master;

    localparam int CW = 4;  // narrow counter so the wrap is reachable in a short run

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata;
    logic          irq;
    logic          mask_wr;
    logic [7:0]    mask_value;
    logic          evt_valid;
    logic          evt_ready;
    logic [7:0]    evt_edges;
    logic [7:0]    evt_level;
    logic [7:0]    toggle_out;
    logic [CW-1:0] evt_count;
    logic          busy;

    logic          pio_rst_n;
    logic [7:0]    pio_ec, pio_mask, pins, set_edges;
    logic [34:0]   bus_log[$];
    logic [34:0]   ent;
    int            n_cmp = 0;
    int            n_fail = 0;
    logic          held;

    always #5 clk = ~clk;

    qsys_btn_irq_master #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .irq(irq),
        .mask_wr(mask_wr), .mask_value(mask_value),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_edges(evt_edges), .evt_level(evt_level),
        .toggle_out(toggle_out), .evt_count(evt_count), .busy(busy)
    );

    // PIO slave: read latency 1, write-1-to-clear edge capture, level irq.
    always @(posedge clk or negedge pio_rst_n) begin
        if (!pio_rst_n) begin
            pio_ec       <= 8'h00;
            pio_mask     <= 8'h00;
            avm_readdata <= 32'h0;
        end else begin
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
                pio_mask <= avm_writedata[7:0];
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
                pio_ec <= (pio_ec & ~avm_writedata[7:0]) | set_edges;
            else
                pio_ec <= pio_ec | set_edges;
            case (avm_address)
                2'd0:    avm_readdata <= {24'h0, pins};
                2'd2:    avm_readdata <= {24'h0, pio_mask};
                2'd3:    avm_readdata <= {24'h0, pio_ec};
                default: avm_readdata <= 32'h0;
            endcase
        end
    end
    assign irq = |(pio_ec & pio_mask);

    always @(posedge clk)
        if (avm_chipselect)
            bus_log.push_back({avm_address, avm_write_n, avm_writedata});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (evt_valid !== 1'b1 && k < 30) begin
            step();
            k++;
        end
        chk(tag, evt_valid, 1);
    endtask

    task automatic pulse_edges(input logic [7:0] e);
        set_edges = e;
        step();
        set_edges = 8'h00;
    endtask

    initial begin
        reset_n = 0; pio_rst_n = 0; evt_ready = 1; mask_wr = 0; mask_value = 0;
        set_edges = 0; pins = 8'hFA;
        repeat (3) step();
        pio_rst_n = 1;
        chk("rst_cs", avm_chipselect, 0);
        chk("rst_wr_n", avm_write_n, 1);
        chk("rst_addr", avm_address, 0);
        chk("rst_wdata", avm_writedata, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_busy", busy, 1);
        chk("rst_count", evt_count, 0);
        chk("rst_toggle", toggle_out, 0);

        // Init mask write after reset release
        reset_n = 1;
        bus_log.delete();
        step();
        chk("init_cs", avm_chipselect, 1);
        chk("init_wr_n", avm_write_n, 0);
        chk("init_addr", avm_address, 2);
        chk("init_wdata", avm_writedata, 32'h000000FF);
        step();
        chk("init_cs_off", avm_chipselect, 0);
        chk("init_busy", busy, 0);
        chk("init_nwr", bus_log.size(), 1);

        // Basic event with exact latency
        bus_log.delete();
        pulse_edges(8'h05);
        chk("t2_irq", irq, 1);
        repeat (5) step();
        chk("t2_valid_n5", evt_valid, 0);
        step();
        chk("t2_valid_n6", evt_valid, 1);
        chk("t2_edges", evt_edges, 8'h05);
        chk("t2_level", evt_level, 8'hFA);
        step();
        chk("t2_valid_n7", evt_valid, 0);
        chk("t2_busy_n7", busy, 0);
        chk("t2_toggle", toggle_out, 8'h05);
        chk("t2_count", evt_count, 1);
        chk("t2_nbus", bus_log.size(), 3);
        ent = bus_log[0];
        chk("t2_bus0", ent[34:32], {2'd3, 1'b1});
        ent = bus_log[1];
        chk("t2_bus1", ent, {2'd3, 1'b0, 32'h05});
        ent = bus_log[2];
        chk("t2_bus2", ent[34:32], {2'd0, 1'b1});

        // Backpressure: 20 stalled cycles
        evt_ready = 0;
        pulse_edges(8'h08);
        repeat (6) step();
        chk("t3_valid", evt_valid, 1);
        chk("t3_edges", evt_edges, 8'h08);
        bus_log.delete();
        held = 1;
        repeat (20) begin
            step();
            if (evt_valid !== 1'b1 || evt_edges !== 8'h08 || evt_level !== 8'hFA || busy !== 1'b1)
                held = 0;
        end
        chk("t3_held", held, 1);
        chk("t3_nbus", bus_log.size(), 0);
        chk("t3_count_stall", evt_count, 1);
        evt_ready = 1;
        step();
        chk("t3_valid_off", evt_valid, 0);
        chk("t3_count", evt_count, 2);
        chk("t3_toggle", toggle_out, 8'h0D);
        step();
        chk("t3_count_once", evt_count, 2);

        // Edge arriving between capture and clear survives
        bus_log.delete();
        pulse_edges(8'h01);
        step(); step();
        pulse_edges(8'h02);
        repeat (3) step();
        chk("t4_valid", evt_valid, 1);
        chk("t4_edges1", evt_edges, 8'h01);
        step();
        chk("t4_irq_again", irq, 1);
        ent = bus_log[1];
        chk("t4_clr", ent, {2'd3, 1'b0, 32'h01});
        wait_valid("t4_wait");
        chk("t4_edges2", evt_edges, 8'h02);
        step();
        chk("t4_toggle", toggle_out, 8'h0E);
        chk("t4_count", evt_count, 4);

        // Mask update while busy takes priority over a pending irq
        pulse_edges(8'h04);
        step();
        mask_wr = 1; mask_value = 8'h0F; set_edges = 8'h02;
        step();
        mask_wr = 0; set_edges = 8'h00;
        repeat (4) step();
        chk("t5_valid", evt_valid, 1);
        chk("t5_edges1", evt_edges, 8'h04);
        bus_log.delete();
        step();
        wait_valid("t5_wait");
        chk("t5_edges2", evt_edges, 8'h02);
        ent = bus_log[0];
        chk("t5_maskwr", ent, {2'd2, 1'b0, 32'h0F});
        ent = bus_log[1];
        chk("t5_ecaddr", ent[34:32], {2'd3, 1'b1});
        step();
        chk("t5_toggle", toggle_out, 8'h08);
        chk("t5_count", evt_count, 6);

        // Counter wrap
        for (int i = 0; i < 9; i++) begin
            pulse_edges(8'h01);
            wait_valid("t6_wait");
            step();
        end
        chk("t6_count_max", evt_count, 4'hF);
        chk("t6_toggle_a", toggle_out, 8'h09);
        pulse_edges(8'h01);
        wait_valid("t6_wait_wrap");
        step();
        chk("t6_count_wrap", evt_count, 0);
        chk("t6_toggle_b", toggle_out, 8'h08);

        // Reset asserted in LV_DATA; surviving edge serviced after INIT_WR
        pulse_edges(8'h03);
        repeat (3) step();
        pulse_edges(8'h04);
        step();
        chk("t7_busy_lv", busy, 1);
        reset_n = 0;
        #2;
        chk("t7_cs", avm_chipselect, 0);
        chk("t7_wr_n", avm_write_n, 1);
        chk("t7_addr", avm_address, 0);
        chk("t7_wdata", avm_writedata, 0);
        chk("t7_valid", evt_valid, 0);
        chk("t7_edges", evt_edges, 0);
        chk("t7_level", evt_level, 0);
        chk("t7_toggle", toggle_out, 0);
        chk("t7_count", evt_count, 0);
        chk("t7_busy", busy, 1);
        step();
        reset_n = 1;
        bus_log.delete();
        step();
        chk("t7_init_cs", avm_chipselect, 1);
        chk("t7_init_wdata", avm_writedata, 32'h000000FF);
        chk("t7_init_addr", avm_address, 2);
        wait_valid("t7_wait");
        chk("t7_edges_srv", evt_edges, 8'h04);
        chk("t7_level_srv", evt_level, 8'hFA);
        step();
        chk("t7_count_srv", evt_count, 1);
        chk("t7_toggle_srv", toggle_out, 8'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
